// File: rtl/ysyx_22041211_mem_arbiter_pkg.sv
// Shared definitions for the IFU/LSU memory arbiter: widths, FSM encoding,
// requester IDs and the round-robin pick rule.
package ysyx_22041211_mem_arbiter_pkg;

   localparam int ADDR_LEN = 32;
   localparam int DATA_LEN = 32;
   localparam int MASK_LEN = DATA_LEN / 8;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_REQ  = 2'b01,
      ST_RSP  = 2'b10
   } arb_state_t;

   localparam logic REQ_IFU = 1'b0;
   localparam logic REQ_LSU = 1'b1;

   // A tie goes to whichever requester did not complete the previous transaction.
   function automatic logic pick_owner(input logic i_v0, input logic i_v1, input logic i_last);
      logic w_pick;
      if (i_v0 && i_v1) begin
         w_pick = ~i_last;
      end else if (i_v1) begin
         w_pick = REQ_LSU;
      end else begin
         w_pick = REQ_IFU;
      end
      return w_pick;
   endfunction

endpackage

// File: rtl/ysyx_22041211_mem_arbiter_if.sv
// One request/response memory channel. The requester side uses master,
// the side that serves requests uses slave.
interface ysyx_22041211_mem_arbiter_if;
   import ysyx_22041211_mem_arbiter_pkg::*;

   logic                req_valid;
   logic                req_ready;
   logic [ADDR_LEN-1:0] addr;
   logic [DATA_LEN-1:0] wdata;
   logic                wen;
   logic [MASK_LEN-1:0] wmask;
   logic                rsp_valid;
   logic                rsp_ready;
   logic [DATA_LEN-1:0] rdata;

   modport master (
      output req_valid, addr, wdata, wen, wmask, rsp_ready,
      input  req_ready, rsp_valid, rdata
   );

   modport slave (
      input  req_valid, addr, wdata, wen, wmask, rsp_ready,
      output req_ready, rsp_valid, rdata
   );

endinterface

// File: rtl/ysyx_22041211_choose.sv
// Generic 2:1 selector: key=0 passes i_in0, key=1 passes i_in1.
module ysyx_22041211_choose #(
   parameter int DATA_LEN = 32
) (
   input  logic                i_key,
   input  logic [DATA_LEN-1:0] i_in0,
   input  logic [DATA_LEN-1:0] i_in1,
   output logic [DATA_LEN-1:0] o_out
);

   // Select between the two inputs.
   always_comb begin
      if (i_key) begin
         o_out = i_in1;
      end else begin
         o_out = i_in0;
      end
   end

endmodule

// File: rtl/ysyx_22041211_mem_arbiter.sv
// Shares one memory port between IFU (r0) and LSU (r1), one outstanding
// transaction at a time, round-robin on simultaneous requests.
module ysyx_22041211_mem_arbiter
   import ysyx_22041211_mem_arbiter_pkg::*;
(
   input logic                          i_clock,
   input logic                          i_reset,
   ysyx_22041211_mem_arbiter_if.slave   io_r0,
   ysyx_22041211_mem_arbiter_if.slave   io_r1,
   ysyx_22041211_mem_arbiter_if.master  io_mem
);

   arb_state_t          r_state;
   logic                r_owner;
   logic                r_last;

   logic                w_live;
   logic                w_in_req;
   logic                w_in_rsp;
   logic                w_own_rsp_ready;
   logic [ADDR_LEN-1:0] w_addr;
   logic [DATA_LEN-1:0] w_wdata;
   logic                w_wen;
   logic [MASK_LEN-1:0] w_wmask;

   // Handshake outputs are forced low while reset is held, even before the first edge.
   assign w_live   = ~i_reset;
   assign w_in_req = w_live && (r_state == ST_REQ);
   assign w_in_rsp = w_live && (r_state == ST_RSP);

   ysyx_22041211_choose #(.DATA_LEN(ADDR_LEN)) u_choose_addr (
      .i_key(r_owner), .i_in0(io_r0.addr), .i_in1(io_r1.addr), .o_out(w_addr)
   );
   ysyx_22041211_choose #(.DATA_LEN(DATA_LEN)) u_choose_wdata (
      .i_key(r_owner), .i_in0(io_r0.wdata), .i_in1(io_r1.wdata), .o_out(w_wdata)
   );
   ysyx_22041211_choose #(.DATA_LEN(1)) u_choose_wen (
      .i_key(r_owner), .i_in0(io_r0.wen), .i_in1(io_r1.wen), .o_out(w_wen)
   );
   ysyx_22041211_choose #(.DATA_LEN(MASK_LEN)) u_choose_wmask (
      .i_key(r_owner), .i_in0(io_r0.wmask), .i_in1(io_r1.wmask), .o_out(w_wmask)
   );

   // Owner's response-ready, used both for the FSM and the memory side.
   always_comb begin
      if (r_owner == REQ_LSU) begin
         w_own_rsp_ready = io_r1.rsp_ready;
      end else begin
         w_own_rsp_ready = io_r0.rsp_ready;
      end
   end

   // Arbitration FSM: grant in IDLE, forward request in REQ, return response in RSP.
   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         r_state <= ST_IDLE;
         r_owner <= REQ_IFU;
         r_last  <= REQ_LSU;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (io_r0.req_valid || io_r1.req_valid) begin
                  r_owner <= pick_owner(io_r0.req_valid, io_r1.req_valid, r_last);
                  r_state <= ST_REQ;
               end else begin
                  r_state <= ST_IDLE;
               end
            end
            ST_REQ: begin
               if (io_mem.req_ready) begin
                  r_state <= ST_RSP;
               end else begin
                  r_state <= ST_REQ;
               end
            end
            ST_RSP: begin
               if (io_mem.rsp_valid && w_own_rsp_ready) begin
                  r_state <= ST_IDLE;
                  r_last  <= r_owner;
               end else begin
                  r_state <= ST_RSP;
               end
            end
            default: begin
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   // Combinational routing between the owner and the memory port.
   always_comb begin
      io_mem.req_valid = w_in_req;
      io_mem.addr      = w_addr;
      io_mem.wdata     = w_wdata;
      io_mem.wen       = w_wen;
      io_mem.wmask     = w_wmask;
      io_mem.rsp_ready = w_in_rsp && w_own_rsp_ready;
      io_r0.req_ready  = w_in_req && (r_owner == REQ_IFU) && io_mem.req_ready;
      io_r1.req_ready  = w_in_req && (r_owner == REQ_LSU) && io_mem.req_ready;
      io_r0.rsp_valid  = w_in_rsp && (r_owner == REQ_IFU) && io_mem.rsp_valid;
      io_r1.rsp_valid  = w_in_rsp && (r_owner == REQ_LSU) && io_mem.rsp_valid;
      io_r0.rdata      = io_mem.rdata;
      io_r1.rdata      = io_mem.rdata;
   end

endmodule
